// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and its typedef.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic in the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Plain combinational sum and carry.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition controller. Adds two WIDTH-bit operands LSB first,
// one bit per clock, through a single shared full_adder.
// Optional feature: define SERIAL_ADDER_OVERFLOW_EN to add the registered
// signed-overflow output.
//
// Handshake: a request is accepted on a rising clock edge where
// start && ready; ready is high only in IDLE, and start seen in any other
// state is dropped (never queued). done pulses for one cycle when sum,
// carry_out (and overflow) take their new values; they then hold until
// the next completion.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the sum bits produced so far, MSB-aligned; the final bit is
    // concatenated on top when the result is committed.
    logic [WIDTH-2:0] sum_sr;
    logic             carry_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_shift;
    logic             last_bit;

    full_adder u_full_adder (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    assign sum_shift = {fa_sum, sum_sr};
    assign last_bit  = (state == RUN) && (bit_cnt == LAST_BIT);
    assign ready     = (state == IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for WIDTH bits, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (bit_cnt == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand load, per-bit shifting and carry tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            bit_cnt <= '0;
        end else if (state == IDLE && start) begin
            a_sr    <= a;
            b_sr    <= b;
            sum_sr  <= '0;
            carry_q <= carry_in;
            bit_cnt <= '0;
        end else if (state == RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_sr  <= sum_shift[WIDTH-1:1];
            carry_q <= fa_cout;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Result registers: written only on the final bit so partial sums never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else if (last_bit) begin
            sum       <= sum_shift;
            carry_out <= fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // carry_q is the carry into the MSB, fa_cout the carry out of it.
            overflow  <= carry_q ^ fa_cout;
`endif
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic [1:0]   state_dbg;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         overflow;
`endif

    int total = 0;
    int bad   = 0;

    logic [W:0] exp_q[$];
    logic       exp_ovf_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .ready     (ready),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
`ifdef SERIAL_ADDER_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: present a request for one edge and record its expected result.
    task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        logic [W:0] full;
        full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        exp_q.push_back(full);
        exp_ovf_q.push_back((av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]));
        a        = av;
        b        = bv;
        carry_in = cv;
        start    = 1'b1;
        step();
        start    = 1'b0;
        a        = W'($urandom_range(0, 255));
        b        = W'($urandom_range(0, 255));
        carry_in = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        carry_in = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        total++;
        if (ready !== 1'b1 || done !== 1'b0 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL reset_ctrl: ready=%b done=%b state=%0d, want 1 0 0", ready, done, state_dbg);
        end
        total++;
        if (sum !== '0 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_result: sum=%h cout=%b, want 00 0", sum, carry_out);
        end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf: overflow=%b, want 0", overflow);
        end
`endif
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[8];
        logic [W-1:0] vb[8];
        logic         vc[8];
        va = '{8'h3C, 8'hFF, 8'h7F, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
        vb = '{8'h41, 8'h01, 8'h01, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 5; i < 8; i++) begin
            va[i] = W'($urandom_range(0, 255));
            vb[i] = W'($urandom_range(0, 255));
            vc[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            int         cyc;
            logic       ready_seen;
            logic [W:0] e;
            logic       eo;
            drive_start(va[i], vb[i], vc[i]);
            cyc = 1;
            ready_seen = 1'b0;
            while (!done && cyc < 40) begin
                if (ready) ready_seen = 1'b1;
                step();
                cyc++;
            end
            total++;
            if (!done || cyc != W + 1 || ready_seen || ready !== 1'b0) begin
                bad++;
                $display("FAIL vec%0d_latency: done=%b cycles=%0d ready_in_run=%b, want done at %0d with ready low",
                         i, done, cyc, ready_seen, W + 1);
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL vec%0d_queue: no expected entry", i);
            end else begin
                e  = exp_q.pop_front();
                eo = exp_ovf_q.pop_front();
                total++;
                if ({carry_out, sum} !== e) begin
                    bad++;
                    $display("FAIL vec%0d_sum: a=%h b=%h cin=%b got cout=%b sum=%h, want cout=%b sum=%h",
                             i, va[i], vb[i], vc[i], carry_out, sum, e[W], e[W-1:0]);
                end
`ifdef SERIAL_ADDER_OVERFLOW_EN
                total++;
                if (overflow !== eo) begin
                    bad++;
                    $display("FAIL vec%0d_ovf: got %b, want %b", i, overflow, eo);
                end
`endif
            end
            step();
            total++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                bad++;
                $display("FAIL vec%0d_pulse: done=%b ready=%b after done, want 0 1", i, done, ready);
            end
        end
    endtask

    task automatic test_ignore_start();
        int         cyc;
        logic       ready_seen;
        logic       extra_done;
        logic [W:0] e;
        drive_start(8'h12, 8'h34, 1'b0);
        repeat (2) step();
        a = 8'hAA;
        b = 8'h55;
        carry_in = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 4;
        ready_seen = 1'b0;
        while (!done && cyc < 40) begin
            if (ready) ready_seen = 1'b1;
            step();
            cyc++;
        end
        total++;
        if (!done || cyc != W + 1 || ready_seen) begin
            bad++;
            $display("FAIL ignore_latency: done=%b cycles=%0d ready_in_run=%b, want done at %0d", done, cyc, ready_seen, W + 1);
        end
        e = exp_q.pop_front();
        void'(exp_ovf_q.pop_front());
        total++;
        if ({carry_out, sum} !== e) begin
            bad++;
            $display("FAIL ignore_sum: got cout=%b sum=%h, want cout=%b sum=%h", carry_out, sum, e[W], e[W-1:0]);
        end
        step();
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL ignore_ready: ready=%b after done, want 1", ready);
        end
        extra_done = 1'b0;
        repeat (15) begin
            step();
            if (done) extra_done = 1'b1;
        end
        total++;
        if (extra_done || sum !== e[W-1:0]) begin
            bad++;
            $display("FAIL ignore_queued: extra_done=%b sum=%h, want 0 and %h", extra_done, sum, e[W-1:0]);
        end
    endtask

    task automatic test_reset_abort();
        int         cyc;
        logic       seen_done;
        logic [W:0] e;
        drive_start(8'h55, 8'h0F, 1'b1);
        void'(exp_q.pop_front());
        void'(exp_ovf_q.pop_front());
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        total++;
        if (ready !== 1'b1 || done !== 1'b0 || sum !== '0 || carry_out !== 1'b0 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL abort_outputs: ready=%b done=%b sum=%h cout=%b state=%0d, want 1 0 00 0 0",
                     ready, done, sum, carry_out, state_dbg);
        end
        step();
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (15) begin
            step();
            if (done) seen_done = 1'b1;
        end
        total++;
        if (seen_done) begin
            bad++;
            $display("FAIL abort_no_done: done=1 seen after abort, want 0");
        end
        drive_start(8'hA5, 8'h5A, 1'b1);
        cyc = 1;
        while (!done && cyc < 40) begin
            step();
            cyc++;
        end
        e = exp_q.pop_front();
        void'(exp_ovf_q.pop_front());
        total++;
        if (!done || cyc != W + 1 || {carry_out, sum} !== e) begin
            bad++;
            $display("FAIL abort_recover: done=%b cycles=%0d cout=%b sum=%h, want done at %0d cout=%b sum=%h",
                     done, cyc, carry_out, sum, W + 1, e[W], e[W-1:0]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int         cyc;
        int         t1;
        logic [W:0] e;
        logic [W:0] full;
        a = 8'hC8;
        b = 8'h64;
        carry_in = 1'b0;
        full = {1'b0, a} + {1'b0, b};
        exp_q.push_back(full);
        start = 1'b1;
        step();
        a = 8'h19;
        b = 8'hE0;
        carry_in = 1'b1;
        full = {1'b0, a} + {1'b0, b} + 9'd1;
        exp_q.push_back(full);
        cyc = 1;
        while (!done && cyc < 40) begin
            step();
            cyc++;
        end
        t1 = cyc;
        e = exp_q.pop_front();
        total++;
        if (!done || {carry_out, sum} !== e) begin
            bad++;
            $display("FAIL b2b_first: done=%b cout=%b sum=%h, want 1 %b %h", done, carry_out, sum, e[W], e[W-1:0]);
        end
        step();
        cyc++;
        while (!done && cyc < 80) begin
            step();
            cyc++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (!done || cyc - t1 != W + 2 || {carry_out, sum} !== e) begin
            bad++;
            $display("FAIL b2b_second: done=%b interval=%0d cout=%b sum=%h, want interval %0d cout=%b sum=%h",
                     done, cyc - t1, carry_out, sum, W + 2, e[W], e[W-1:0]);
        end
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
